regfile_access_arbiter: RTL

//  Shares the register file's write port and rs1 read port between the core writeback path and a debug host (UART/JTAG bridge).

---
 rtl/regfile_access_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_access_arbiter.sv
// Register file port arbiter: the core owns the write port and the rs1 read port,
// except when a debug host borrows them for a single stalled access cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ports pass through from the core; a debug request may be accepted
// STALL  | core frozen, ports quiet for one settle cycle
// ACCESS | debug write drives rd/wd, or debug read drives rs1 and captures data
// RESP   | core still frozen, dbg_ack high, guard counter reloaded
module regfile_access_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 5,
    parameter int MIN_CORE_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_reg_write,
    input  logic [ADDR_W-1:0] core_rd,
    input  logic [XLEN-1:0]   core_wd,
    input  logic [ADDR_W-1:0] core_rs1,
    input  logic [ADDR_W-1:0] core_rs2,
    output logic              core_stall,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]   rf_rs1_val,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_ack,
    output logic [XLEN-1:0]   dbg_rdata
);

    localparam int GAP_W = (MIN_CORE_GAP > 0) ? $clog2(MIN_CORE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_CORE_GAP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STALL  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic              grant;

    assign grant = (state == S_IDLE) && dbg_req && (gap_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant) state_nxt = S_STALL;
            S_STALL:  state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The request is captured once at accept so the host may change dbg_* freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gap_cnt   <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= (state == S_ACCESS);
            if (grant) begin
                lat_we    <= dbg_we;
                lat_addr  <= dbg_addr;
                lat_wdata <= dbg_wdata;
            end
            if ((state == S_ACCESS) && !lat_we) begin
                dbg_rdata <= (lat_addr == '0) ? '0 : rf_rs1_val;
            end
            if (state == S_RESP) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_IDLE) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    always_comb begin
        core_stall   = (state != S_IDLE);
        rf_reg_write = core_reg_write;
        rf_rd        = core_rd;
        rf_wd        = core_wd;
        rf_rs1       = core_rs1;
        case (state)
            S_IDLE: begin
            end
            S_ACCESS: begin
                if (lat_we) begin
                    rf_reg_write = 1'b1;
                    rf_rd        = lat_addr;
                    rf_wd        = lat_wdata;
                end else begin
                    rf_reg_write = 1'b0;
                    rf_rs1       = lat_addr;
                end
            end
            default: begin
                rf_reg_write = 1'b0;
            end
        endcase
    end

    assign rf_rs2 = core_rs2;

endmodule
